// File: rtl/eth_fcs_insert.sv
// Ethernet FCS inserter: passes payload, zero-pads short frames,
// then appends the CRC-32 FCS low byte first.
module eth_fcs_insert #(
  parameter int MIN_LEN = 60,
  parameter bit PAD_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [31:0] fcs,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_FCS  = 2'd3;

  localparam int CW = $clog2(MIN_LEN + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [31:0]   crc;
  logic [31:0]   fcs_q;
  logic [1:0]    fcs_idx;
  logic          fcs_sent;
  logic [7:0]    fcs_byte;
  logic          adv;
  logic          in_beat;
  logic          out_end;

  assign adv = ~m_valid | m_ready;
  assign s_ready = reset_n & adv &
    ((state == S_IDLE) | (state == S_DATA));
  assign in_beat = s_valid & s_ready;
  assign out_end = m_valid & m_ready & m_last;

  assign count_inc = (count == MIN_C) ? count : count + 1'b1;

  // Final FCS becomes visible on the same beat that retires it
  assign frame_done = out_end;
  assign fcs = out_end ? ~crc : fcs_q;

  always_comb begin
    fcs_byte = 8'h00;
    unique case (fcs_idx)
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      m_data   <= 8'h00;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      fcs_q    <= 32'h0;
      count    <= '0;
      crc      <= CRC_INIT;
      fcs_idx  <= 2'd0;
      fcs_sent <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DATA: begin
          if (in_beat) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_byte(crc, s_data);
            count   <= count_inc;
            if (!s_last)
              state <= S_DATA;
            else if (PAD_EN && (count_inc < MIN_C))
              state <= S_PAD;
            else
              state <= S_FCS;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        S_PAD: begin
          if (adv) begin
            m_data  <= 8'h00;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_byte(crc, 8'h00);
            count   <= count_inc;
            if (count_inc == MIN_C)
              state <= S_FCS;
          end
        end
        S_FCS: begin
          if (out_end) begin
            state    <= S_IDLE;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            fcs_q    <= ~crc;
            crc      <= CRC_INIT;
            count    <= '0;
            fcs_idx  <= 2'd0;
            fcs_sent <= 1'b0;
          end else if (adv && !fcs_sent) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (fcs_idx == 2'd3);
            fcs_idx <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3)
              fcs_sent <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Directed bench for eth_fcs_insert: unpadded and padded instances,
// stalls, back-to-back frames and mid-frame reset.
module tb_eth_fcs_insert;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;
  logic        s_valid0 = 1'b0;
  logic        s_valid1 = 1'b0;

  logic        s_ready0, m_valid0, m_last0, frame_done0;
  logic [7:0]  m_data0;
  logic [31:0] fcs0;
  logic        s_ready1, m_valid1, m_last1, frame_done1;
  logic [7:0]  m_data1;
  logic [31:0] fcs1;

  logic        sel = 1'b0;
  logic        sr, mv, ml, fd;
  logic [7:0]  md;
  logic [31:0] fc;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [31:0] exp_fcs;
  logic [31:0] fcs_seen;
  int fd_cnt, ml_cnt, last_pos, stall_bad, sr_bad;
  bit timed_out, first_sr;

  always #5 clk = ~clk;

  eth_fcs_insert #(.MIN_LEN(60), .PAD_EN(1'b0)) u_nopad (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid0), .s_last(s_last),
    .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
    .m_ready(m_ready),
    .fcs(fcs0), .frame_done(frame_done0)
  );

  eth_fcs_insert #(.MIN_LEN(60), .PAD_EN(1'b1)) u_pad (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid1), .s_last(s_last),
    .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready),
    .fcs(fcs1), .frame_done(frame_done1)
  );

  always_comb begin
    sr = sel ? s_ready1 : s_ready0;
    mv = sel ? m_valid1 : m_valid0;
    ml = sel ? m_last1 : m_last0;
    fd = sel ? frame_done1 : frame_done0;
    md = sel ? m_data1 : m_data0;
    fc = sel ? fcs1 : fcs0;
  end

  function automatic logic [31:0] sw_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[k]) begin
      c = c ^ {24'h0, q[k]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(input bit pad);
    exp_q = in_q;
    if (pad) while (exp_q.size() < 60) exp_q.push_back(8'h00);
    exp_fcs = sw_crc(exp_q);
    exp_q.push_back(exp_fcs[7:0]);
    exp_q.push_back(exp_fcs[15:8]);
    exp_q.push_back(exp_fcs[23:16]);
    exp_q.push_back(exp_fcs[31:24]);
  endtask

  task automatic load_123;
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic set_valid(input logic v);
    if (sel) s_valid1 = v;
    else s_valid0 = v;
  endtask

  // Drives in_q into the selected instance and collects one output frame
  task automatic run_frame(input bit rnd);
    int idx, cyc;
    bit done, prev_stall, last_in;
    logic [7:0] prev_md;
    out_q.delete();
    idx = 0; cyc = 0; done = 0;
    fd_cnt = 0; ml_cnt = 0; last_pos = -1;
    stall_bad = 0; sr_bad = 0; timed_out = 0;
    prev_stall = 0; prev_md = 8'h00; last_in = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      set_valid(idx < in_q.size());
      s_data = (idx < in_q.size()) ? in_q[idx] : 8'h00;
      s_last = (idx == in_q.size() - 1);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 1) first_sr = sr;
      if (prev_stall && md !== prev_md) stall_bad++;
      if (last_in && sr) sr_bad++;
      if (sr && idx < in_q.size()) begin
        if (idx == in_q.size() - 1) last_in = 1;
        idx++;
      end
      if (fd && !(mv && m_ready && ml)) fd_cnt += 100;
      if (mv && m_ready) begin
        out_q.push_back(md);
        if (ml) begin
          ml_cnt++;
          last_pos = out_q.size() - 1;
        end
        if (fd) begin
          fd_cnt++;
          fcs_seen = fc;
          done = 1;
        end
      end
      prev_stall = mv && !m_ready;
      prev_md = md;
    end
    if (!done) timed_out = 1;
    set_valid(1'b0);
    s_last = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_frame(input string nm);
    bit bad;
    vectors++;
    if (timed_out) begin
      $display("FAIL %s_timeout no frame_done within budget", nm);
      miscompares++;
    end
    vectors++;
    bad = (out_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[k]) if (out_q[k] !== exp_q[k]) bad = 1;
    if (bad) begin
      $display("FAIL %s_bytes got %0d bytes, required %0d bytes %p",
               nm, out_q.size(), exp_q.size(), exp_q.size() < 20 ? exp_q : out_q);
      miscompares++;
    end
    vectors++;
    if (fcs_seen !== exp_fcs) begin
      $display("FAIL %s_fcs got %h required %h", nm, fcs_seen, exp_fcs);
      miscompares++;
    end
    vectors++;
    if (ml_cnt != 1 || last_pos != exp_q.size() - 1 || fd_cnt != 1) begin
      $display("FAIL %s_last got m_last x%0d at %0d fd %0d required x1 at %0d fd 1",
               nm, ml_cnt, last_pos, fd_cnt, exp_q.size() - 1);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (s_ready0 !== 1'b0 || s_ready1 !== 1'b0) begin
      $display("FAIL reset_s_ready got %b%b required 00", s_ready0, s_ready1);
      miscompares++;
    end
    vectors++;
    if ({m_valid0, m_last0, frame_done0, m_data0, fcs0} !== 43'h0) begin
      $display("FAIL reset_outputs got v%b l%b d%b %h %h required all zero",
               m_valid0, m_last0, frame_done0, m_data0, fcs0);
      miscompares++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (s_ready0 !== 1'b1 || s_ready1 !== 1'b1) begin
      $display("FAIL reset_release_ready got %b%b required 11", s_ready0, s_ready1);
      miscompares++;
    end
  endtask

  task automatic test_nopad;
    sel = 1'b0;
    load_123();
    build_exp(1'b0);
    vectors++;
    if (exp_fcs !== sw_crc(in_q) || sw_crc(in_q) !== 32'hCBF4_3926) begin
      $display("FAIL nopad_model got %h required cbf43926", sw_crc(in_q));
      miscompares++;
    end
    run_frame(1'b0);
    check_frame("nopad");
    @(negedge clk);
    #1;
    vectors++;
    if (fd !== 1'b0 || fc !== 32'hCBF4_3926) begin
      $display("FAIL nopad_hold got fd %b fcs %h required 0 cbf43926", fd, fc);
      miscompares++;
    end
  endtask

  task automatic test_pad;
    sel = 1'b1;
    load_123();
    build_exp(1'b1);
    run_frame(1'b0);
    check_frame("pad");
    vectors++;
    if (sr_bad != 0) begin
      $display("FAIL pad_s_ready got %0d ready cycles in PAD/FCS required 0", sr_bad);
      miscompares++;
    end
  endtask

  task automatic test_long;
    sel = 1'b1;
    in_q.delete();
    for (int i = 0; i < 64; i++) in_q.push_back(8'(i * 7 + 3));
    build_exp(1'b1);
    run_frame(1'b0);
    check_frame("long");
  endtask

  task automatic test_stall;
    sel = 1'b0;
    load_123();
    build_exp(1'b0);
    run_frame(1'b1);
    check_frame("stall");
    vectors++;
    if (stall_bad != 0) begin
      $display("FAIL stall_hold got %0d changed stalled bytes required 0", stall_bad);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    in_q.delete();
    in_q.push_back(8'h00);
    build_exp(1'b0);
    run_frame(1'b0);
    check_frame("b2b_first");
    vectors++;
    if (fcs_seen !== 32'hD202_EF8D) begin
      $display("FAIL b2b_zero_fcs got %h required d202ef8d", fcs_seen);
      miscompares++;
    end
    load_123();
    build_exp(1'b0);
    run_frame(1'b0);
    check_frame("b2b_second");
    vectors++;
    if (first_sr !== 1'b1) begin
      $display("FAIL b2b_no_bubble got s_ready %b required 1", first_sr);
      miscompares++;
    end
  endtask

  task automatic test_midreset;
    int seen;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid0 = 1'b1;
      s_data = 8'hA0 + 8'(i);
      s_last = 1'b0;
      m_ready = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (m_valid0 !== 1'b0 || s_ready0 !== 1'b0 || fcs0 !== 32'h0) begin
      $display("FAIL midreset_clear got v%b r%b fcs %h required 0 0 0",
               m_valid0, s_ready0, fcs0);
      miscompares++;
    end
    s_valid0 = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (m_valid0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      $display("FAIL midreset_residue got %0d output beats required 0", seen);
      miscompares++;
    end
    load_123();
    build_exp(1'b0);
    run_frame(1'b0);
    check_frame("midreset");
  endtask

  initial begin
    test_reset();
    test_nopad();
    test_pad();
    test_long();
    test_stall();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
